// File: rtl/cla_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cla_seq_ctrl
// Description : Multi-cycle wide adder sequencer. Reuses one external 4-bit
//               carry-look-ahead slice, LS nibble first, feeding the
//               registered slice carry-out back as the next carry-in.
// Revision    : 1.0 - initial release
// ============================================================================
module cla_seq_ctrl #(
    parameter int NSLICE = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [4*NSLICE-1:0]   i_a,
    input  logic [4*NSLICE-1:0]   i_b,
    input  logic                  i_cin,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [4*NSLICE-1:0]   o_sum,
    output logic                  o_cout,
    output logic [3:0]            o_slc_a,
    output logic [3:0]            o_slc_b,
    output logic                  o_slc_cin,
    input  logic [3:0]            i_slc_sum,
    input  logic                  i_slc_cout
);

    localparam int c_W     = 4 * NSLICE;
    localparam int c_IDX_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_IDX_W-1:0]   r_idx;
    logic [c_W-1:0]       r_a;
    logic [c_W-1:0]       r_b;
    logic                 r_carry;
    logic [c_W-1:0]       r_sum;
    logic                 r_cout;
    logic                 r_busy;
    logic                 r_done;

    logic [3:0]           w_slc_a;
    logic [3:0]           w_slc_b;
    logic                 w_slc_cin;

    // Sequencer FSM: accept operands, walk nibbles through the slice, pulse done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_a     <= i_a;
                        r_b     <= i_b;
                        r_carry <= i_cin;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum[4*r_idx +: 4] <= i_slc_sum;
                    r_carry             <= i_slc_cout;
                    if (r_idx == c_IDX_LAST) begin
                        // Last nibble: its carry-out is the final carry
                        r_cout  <= i_slc_cout;
                        r_idx   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    // start is not looked at here; a held start is seen next cycle
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Slice drive: current nibble pair and carry while running, zeros otherwise
    always_comb begin
        w_slc_a   = 4'h0;
        w_slc_b   = 4'h0;
        w_slc_cin = 1'b0;
        if (r_state == S_RUN) begin
            w_slc_a   = r_a[4*r_idx +: 4];
            w_slc_b   = r_b[4*r_idx +: 4];
            w_slc_cin = r_carry;
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_sum     = r_sum;
    assign o_cout    = r_cout;
    assign o_slc_a   = w_slc_a;
    assign o_slc_b   = w_slc_b;
    assign o_slc_cin = w_slc_cin;

endmodule
`default_nettype wire

// File: tb/tb_cla_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cla_seq_ctrl
// Description : Self-checking bench for cla_seq_ctrl with NSLICE=4. The
//               4-bit slice is modelled combinationally; results are compared
//               against plain integer addition.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_seq_ctrl;

    localparam int NSLICE = 4;
    localparam int W      = 4 * NSLICE;

    logic           clk;
    logic           rst_n;
    logic           i_start;
    logic [W-1:0]   i_a;
    logic [W-1:0]   i_b;
    logic           i_cin;
    logic           o_busy;
    logic           o_done;
    logic [W-1:0]   o_sum;
    logic           o_cout;
    logic [3:0]     o_slc_a;
    logic [3:0]     o_slc_b;
    logic           o_slc_cin;
    logic [3:0]     w_slc_sum;
    logic           w_slc_cout;

    int n_checks = 0;
    int n_fail   = 0;

    cla_seq_ctrl #(.NSLICE(NSLICE)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (i_start),
        .i_a        (i_a),
        .i_b        (i_b),
        .i_cin      (i_cin),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_sum      (o_sum),
        .o_cout     (o_cout),
        .o_slc_a    (o_slc_a),
        .o_slc_b    (o_slc_b),
        .o_slc_cin  (o_slc_cin),
        .i_slc_sum  (w_slc_sum),
        .i_slc_cout (w_slc_cout)
    );

    // Combinational 4-bit adder slice
    assign {w_slc_cout, w_slc_sum} = {1'b0, o_slc_a} + {1'b0, o_slc_b} + {4'b0, o_slc_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Carry into nibble k of a+b+c, computed from the low 4k bits only
    function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic c, input int k);
        longint unsigned mask, s;
        mask = (64'd1 << (4*k)) - 1;
        s    = (longint'(a) & mask) + (longint'(b) & mask) + longint'(c);
        return logic'((s >> (4*k)) & 1);
    endfunction

    // One add: pulse start, optionally poke start during RUN, check timing and result
    task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                           input string name, input bit poke);
        logic [W:0] exp;
        int busy_cnt, done_cnt, done_at, slc_bad, both_bad, nib_bad;
        exp = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        busy_cnt = 0; done_cnt = 0; done_at = -1; slc_bad = 0; both_bad = 0; nib_bad = 0;
        @(negedge clk);
        i_a = a; i_b = b; i_cin = c; i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        i_a = W'($urandom); i_b = W'($urandom); i_cin = 1'($urandom);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (poke && k == 1) begin i_start = 1'b1; i_a = 16'hAAAA; end
            if (poke && k == 2) i_start = 1'b0;
            if (o_busy) begin
                busy_cnt++;
                if (k < NSLICE) begin
                    if (o_slc_a !== a[4*k +: 4] || o_slc_b !== b[4*k +: 4] ||
                        o_slc_cin !== carry_into(a, b, c, k))
                        nib_bad++;
                end
            end else if (o_slc_a !== 4'h0 || o_slc_b !== 4'h0 || o_slc_cin !== 1'b0) begin
                slc_bad++;
            end
            if (o_busy && o_done) both_bad++;
            if (o_done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
        end
        n_checks++; if (busy_cnt !== NSLICE) begin n_fail++; $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cnt, NSLICE); end
        n_checks++; if (done_at !== NSLICE) begin n_fail++; $display("FAIL %s done_latency: got %0d want %0d", name, done_at, NSLICE); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL %s done_count: got %0d want 1", name, done_cnt); end
        n_checks++; if (nib_bad !== 0) begin n_fail++; $display("FAIL %s slice_drive_run: got %0d bad cycles want 0", name, nib_bad); end
        n_checks++; if (slc_bad !== 0) begin n_fail++; $display("FAIL %s slice_zero_idle: got %0d bad cycles want 0", name, slc_bad); end
        n_checks++; if (both_bad !== 0) begin n_fail++; $display("FAIL %s busy_and_done: got %0d cycles want 0", name, both_bad); end
        n_checks++; if (o_sum !== exp[W-1:0]) begin n_fail++; $display("FAIL %s sum: got %h want %h", name, o_sum, exp[W-1:0]); end
        n_checks++; if (o_cout !== exp[W]) begin n_fail++; $display("FAIL %s cout: got %b want %b", name, o_cout, exp[W]); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_start = 1'b0; i_a = '0; i_b = '0; i_cin = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({o_busy, o_done, o_sum, o_cout, o_slc_a, o_slc_b, o_slc_cin} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b slc=%h/%h/%b want all zero",
                     o_busy, o_done, o_sum, o_cout, o_slc_a, o_slc_b, o_slc_cin);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_add(16'h1234, 16'h4321, 1'b0, "add_1234_4321", 1'b0);
        run_add(16'hFFFF, 16'h0001, 1'b0, "ripple_ffff_1", 1'b0);
        run_add(16'h0005, 16'h0009, 1'b1, "cin_5_9", 1'b0);
        run_add(16'h0003, 16'h0008, 1'b1, "cin_3_8", 1'b0);
        run_add(16'hFFFF, 16'hFFFF, 1'b1, "max_all", 1'b0);
    endtask

    task automatic test_start_ignored();
        run_add(16'h0F0F, 16'h1111, 1'b0, "start_in_run", 1'b1);
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        i_a = 16'h7777; i_b = 16'h9999; i_cin = 1'b1; i_start = 1'b1;
        @(posedge clk);
        #1 i_start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_busy, o_done, o_sum, o_cout, o_slc_a, o_slc_b, o_slc_cin} !== '0) begin
            n_fail++;
            $display("FAIL midrun_reset: got busy=%b done=%b sum=%h cout=%b slc=%h/%h/%b want all zero",
                     o_busy, o_done, o_sum, o_cout, o_slc_a, o_slc_b, o_slc_cin);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_add(16'h8000, 16'h8000, 1'b0, "after_reset_8000", 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++)
            run_add(W'($urandom), W'($urandom), 1'($urandom), "random", 1'b0);
    endtask

    // start held high: back-to-back adds, done every NSLICE+2 cycles, sum held after done
    task automatic test_back_to_back();
        logic [W:0] exp, prev;
        logic [W-1:0] na, nb;
        logic nc;
        int dones, last_done, gap_bad, val_bad, hold_bad, slc_bad;
        bit after_done;
        dones = 0; last_done = -1; gap_bad = 0; val_bad = 0; hold_bad = 0; slc_bad = 0;
        after_done = 1'b0; prev = '0;
        @(negedge clk);
        na = W'($urandom); nb = W'($urandom); nc = 1'($urandom);
        i_a = na; i_b = nb; i_cin = nc; i_start = 1'b1;
        exp = {1'b0, na} + {1'b0, nb} + {{W{1'b0}}, nc};
        for (int cyc = 0; cyc < 60 && dones < 4; cyc++) begin
            @(negedge clk);
            if (after_done) begin
                if ({o_cout, o_sum} !== prev) hold_bad++;
                after_done = 1'b0;
            end
            if (!o_busy && (o_slc_a !== 4'h0 || o_slc_b !== 4'h0 || o_slc_cin !== 1'b0)) slc_bad++;
            if (o_done) begin
                if ({o_cout, o_sum} !== exp) begin
                    val_bad++;
                    $display("FAIL b2b_result: got %b_%h want %b_%h", o_cout, o_sum, exp[W], exp[W-1:0]);
                end
                if (last_done >= 0 && cyc - last_done != NSLICE + 2) gap_bad++;
                last_done = cyc;
                dones++;
                prev = exp;
                after_done = 1'b1;
                na = W'($urandom); nb = W'($urandom); nc = 1'($urandom);
                i_a = na; i_b = nb; i_cin = nc;
                exp = {1'b0, na} + {1'b0, nb} + {{W{1'b0}}, nc};
            end
        end
        i_start = 1'b0;
        n_checks++; if (dones !== 4) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 4", dones); end
        n_checks++; if (gap_bad !== 0) begin n_fail++; $display("FAIL b2b_done_spacing: got %0d bad gaps want 0", gap_bad); end
        n_checks++; if (val_bad !== 0) begin n_fail++; $display("FAIL b2b_values: got %0d bad results want 0", val_bad); end
        n_checks++; if (hold_bad !== 0) begin n_fail++; $display("FAIL b2b_sum_hold: got %0d bad cycles want 0", hold_bad); end
        n_checks++; if (slc_bad !== 0) begin n_fail++; $display("FAIL b2b_slice_zero: got %0d bad cycles want 0", slc_bad); end
        repeat (NSLICE + 3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_ignored();
        test_reset_midrun();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
